mfp_ahb_sevenseg_gen: RTL and testbench
=======================================

# mfp_ahb_sevenseg_gen

Parametrised AHB-Lite seven-segment display controller: the next-generation display peripheral on the MIPSfpga AHB bus. It supports a configurable digit count, per-digit raw/hex mode, per-digit blink, global PWM brightness and register readback. The digit scan, decoder and PWM are internal. The block drives multiplexed common-anode displays with active-low anodes and segments.

## Interface
Parameters:
- NDIGITS, 8, number of digits (1..16)
- REFRESH_LOG2, 16, log2 of cycles per digit scan slot (>= 4)
- BLINK_LOG2, 25, log2 of the full blink period in cycles (> REFRESH_LOG2)

Ports:
- HCLK  in  1  bus and display clock
- HRESETn  in  1  reset; asynchronous, active-low
- HADDR  in  8  byte address, low 8 bits
- HWDATA  in  32  write data (data phase)
- HWRITE  in  1  write strobe (address phase)
- HSEL  in  1  slave select (address phase)
- HRDATA  out  32  read data (data phase)
- DISPENOUT  out  NDIGITS  anode enables; active-low; one-hot-low or all ones
- DISPOUT  out  8  bit 7 = dp, bits [6:0] = segments g..a; active-low

## Operation
- Address phase: HADDR, HWRITE and HSEL are registered on each HCLK edge.
- Data phase write: when the registered HSEL and HWRITE are both 1, the register selected by the registered HADDR loads HWDATA. Only full-word writes exist; HSIZE is not used.
- Register map (bits at index NDIGITS and above read 0 and ignore writes):
  - 0x00 BLANK[NDIGITS-1:0]: 1 = digit off. Reset value: bits at index NDIGITS/2 and above are 1, the rest 0.
  - 0x04 DP[NDIGITS-1:0]: 1 = decimal point off. Reset value: all 1 except bit 3 (when NDIGITS > 3).
  - 0x08 RAW[NDIGITS-1:0]: 1 = the digit byte is a raw active-low pattern for segments [6:0]. Reset 0.
  - 0x0C BLINK[NDIGITS-1:0]: 1 = the digit blinks. Reset 0.
  - 0x10 + 4j, for j = 0 .. ceil(NDIGITS/4)-1: byte lane k holds the code for digit 4j+k. Reset 0. Lanes for digits at index NDIGITS and above are ignored.
  - 0x20 CTRL: bit 0 = ENABLE (reset 1); bits [11:8] = BRIGHT (reset 15).
  - All other addresses: writes are ignored and reads return 0.
- Code decode, in hex mode (byte bits [4:0]):
  - 0x00–0x0F: hex glyph. The active-low [6:0] values for 0..F are C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E, each masked to 7 bits.
  - 0x11: '-' (0x3F).
  - 0x12: '_' (0x77).
  - All other codes: blank (0x7F).
  - Byte bits [7:5] are ignored.
- Scan:
  - A REFRESH_LOG2-bit prescaler counts freely.
  - On prescaler wrap, the digit index advances by 1 and wraps from NDIGITS-1 to 0.
- PWM: PH = prescaler[MSB:MSB-3]. The digit is in its lit window when PH <= BRIGHT. BRIGHT=15 gives always on; BRIGHT=0 gives 1/16 duty.
- Blink: a BLINK_LOG2-bit free-running counter runs. While its MSB is 1, digits with BLINK=1 are dark.
- Digit i (current index) is lit when all of the following hold: ENABLE=1, BLANK[i]=0, it is in its lit window, and it is not blink-dark.
  - Lit: DISPENOUT has only bit i = 0, and DISPOUT = {DP[i], seg}.
  - Not lit: DISPENOUT and DISPOUT are all ones.
- Readback: HRDATA is driven combinationally from the registered address when the registered HSEL=1 and registered HWRITE=0; otherwise HRDATA = 0.

## Timing
- Reset (asynchronous, any time including mid-scan):
  - DISPENOUT and DISPOUT are all ones, and HRDATA = 0.
  - Prescaler, index and blink counter are 0.
  - Registers take their reset values immediately.
- After reset release: digit 0 is first, and the index reaches 1 after 2^REFRESH_LOG2 cycles.
- Writes: an address phase at edge N with its data phase sampled at edge N+1 updates the register at edge N+1. Back-to-back writes are supported at one per cycle.
- Reads:
  - HRDATA is valid during the data-phase cycle.
  - A read whose address phase immediately follows a write to the same register returns the new value.
- DISPENOUT and DISPOUT are registered. A register or index change appears on the outputs one HCLK later.
- Simultaneous write and scan advance: the new data is applied at the first output update after the write edge. No glitch beyond one cycle is permitted.
- DISPENOUT never has more than one bit low in any cycle.

## Test plan
- Reset with NDIGITS=8, REFRESH_LOG2=4 -> read 0x00 = 0xF0, 0x04 = 0xF7, 0x20 = 0x0F01. Outputs are 0xFF while the digits are blanked or the state is reset.
- Write 0x00 = 0x00 and 0x10 = 0x0F_0A_01_00 -> digits 0..3 show DISPOUT C0, F9, 88, 8E (digit 3 shows dp lit: 0x0E). Each digit slot lasts 16 cycles; the index wraps 7 -> 0.
- Write 0x08 = 0x01 and byte0 = 0x5A -> digit 0 DISPOUT = 0xDA (dp off, raw 0x5A).
- Write CTRL = 0x0001 (BRIGHT=0) -> each slot lit for exactly 1 of 16 cycles. Write CTRL = 0x0000 -> DISPENOUT stays 0xFF.
- BLINK=0x02 with BLINK_LOG2=8 -> digit 1 is dark for 128-cycle halves; other digits are unaffected.
- NDIGITS=4: write 0x00 = 0xFFFF_FFF0 -> reads back 0x0. The index wraps 3 -> 0. Read 0x14 = 0, and an unmapped read at 0x3C = 0. Assert HRESETn low mid-slot -> outputs are 0xFF in the same cycle.

Source files
------------

// File: rtl/mfp_ahb_sevenseg_gen.sv
// AHB-Lite multiplexed seven-segment controller for common-anode displays.
// It provides per-digit hex/raw decode, blink and decimal point, plus PWM brightness.
module mfp_ahb_sevenseg_gen #(
  parameter int NDIGITS      = 8,
  parameter int REFRESH_LOG2 = 16,
  parameter int BLINK_LOG2   = 25
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [7:0]         HADDR,
  input  logic [31:0]        HWDATA,
  input  logic               HWRITE,
  input  logic               HSEL,
  output logic [31:0]        HRDATA,
  output logic [NDIGITS-1:0] DISPENOUT,
  output logic [7:0]         DISPOUT
);

  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  function automatic logic [NDIGITS-1:0] blank_reset();
    logic [NDIGITS-1:0] v;
    for (int i = 0; i < NDIGITS; i++) v[i] = (i >= NDIGITS / 2);
    return v;
  endfunction

  function automatic logic [NDIGITS-1:0] dp_reset();
    logic [NDIGITS-1:0] v;
    for (int i = 0; i < NDIGITS; i++) v[i] = (i != 3);
    return v;
  endfunction

  localparam logic [NDIGITS-1:0] BLANK_RST = blank_reset();
  localparam logic [NDIGITS-1:0] DP_RST    = dp_reset();

  // Four digit codes share each word, starting at 0x10.
  function automatic logic [7:0] code_addr(input int d);
    return 8'(16 + 4 * (d / 4));
  endfunction

  function automatic logic [6:0] hex_seg(input logic [4:0] c);
    case (c)
      5'h00: hex_seg = 7'h40;
      5'h01: hex_seg = 7'h79;
      5'h02: hex_seg = 7'h24;
      5'h03: hex_seg = 7'h30;
      5'h04: hex_seg = 7'h19;
      5'h05: hex_seg = 7'h12;
      5'h06: hex_seg = 7'h02;
      5'h07: hex_seg = 7'h78;
      5'h08: hex_seg = 7'h00;
      5'h09: hex_seg = 7'h10;
      5'h0A: hex_seg = 7'h08;
      5'h0B: hex_seg = 7'h03;
      5'h0C: hex_seg = 7'h46;
      5'h0D: hex_seg = 7'h21;
      5'h0E: hex_seg = 7'h06;
      5'h0F: hex_seg = 7'h0E;
      5'h11: hex_seg = 7'h3F;
      5'h12: hex_seg = 7'h77;
      default: hex_seg = 7'h7F;
    endcase
  endfunction

  logic [7:0]              haddr_reg;
  logic                    hwrite_reg;
  logic                    hsel_reg;
  logic [NDIGITS-1:0]      blank_reg;
  logic [NDIGITS-1:0]      dp_reg;
  logic [NDIGITS-1:0]      raw_reg;
  logic [NDIGITS-1:0]      blink_reg;
  logic [7:0]              code_reg [NDIGITS];
  logic                    enable_reg;
  logic [3:0]              bright_reg;
  logic [REFRESH_LOG2-1:0] presc_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [BLINK_LOG2-1:0]   blink_cnt_reg;
  logic [NDIGITS-1:0]      dispen_reg;
  logic [7:0]              dispout_reg;

  logic                    wr_en;
  logic                    presc_wrap;
  logic [3:0]              ph;
  logic [7:0]              cur_code;
  logic [6:0]              seg;
  logic                    lit;
  logic [NDIGITS-1:0]      anode_next;
  logic [7:0]              dispout_next;

  assign wr_en      = hsel_reg && hwrite_reg;
  assign presc_wrap = &presc_reg;
  assign ph         = presc_reg[REFRESH_LOG2-1 -: 4];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr_reg  <= '0;
      hwrite_reg <= 1'b0;
      hsel_reg   <= 1'b0;
    end else begin
      haddr_reg  <= HADDR;
      hwrite_reg <= HWRITE;
      hsel_reg   <= HSEL;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      blank_reg  <= BLANK_RST;
      dp_reg     <= DP_RST;
      raw_reg    <= '0;
      blink_reg  <= '0;
      enable_reg <= 1'b1;
      bright_reg <= 4'hF;
      for (int d = 0; d < NDIGITS; d++) code_reg[d] <= '0;
    end else if (wr_en) begin
      case (haddr_reg)
        8'h00: blank_reg <= HWDATA[NDIGITS-1:0];
        8'h04: dp_reg    <= HWDATA[NDIGITS-1:0];
        8'h08: raw_reg   <= HWDATA[NDIGITS-1:0];
        8'h0C: blink_reg <= HWDATA[NDIGITS-1:0];
        8'h20: begin
          enable_reg <= HWDATA[0];
          bright_reg <= HWDATA[11:8];
        end
        default: ;
      endcase
      for (int d = 0; d < NDIGITS; d++) begin
        if (haddr_reg == code_addr(d)) code_reg[d] <= HWDATA[8*(d%4) +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      presc_reg     <= '0;
      idx_reg       <= '0;
      blink_cnt_reg <= '0;
    end else begin
      presc_reg     <= presc_reg + REFRESH_LOG2'(1);
      blink_cnt_reg <= blink_cnt_reg + BLINK_LOG2'(1);
      if (presc_wrap) begin
        idx_reg <= (idx_reg == IDX_W'(NDIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
      end
    end
  end

  always_comb begin
    cur_code     = code_reg[idx_reg];
    seg          = raw_reg[idx_reg] ? cur_code[6:0] : hex_seg(cur_code[4:0]);
    lit          = enable_reg && !blank_reg[idx_reg] && (ph <= bright_reg) &&
                   !(blink_reg[idx_reg] && blink_cnt_reg[BLINK_LOG2-1]);
    dispout_next = lit ? {dp_reg[idx_reg], seg} : 8'hFF;
  end

  for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_anode
    assign anode_next[gi] = !(lit && (idx_reg == IDX_W'(gi)));
  end

  // Outputs are registered so that at most one anode can be low at any time.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dispen_reg  <= '1;
      dispout_reg <= 8'hFF;
    end else begin
      dispen_reg  <= anode_next;
      dispout_reg <= dispout_next;
    end
  end

  assign DISPENOUT = dispen_reg;
  assign DISPOUT   = dispout_reg;

  always_comb begin
    HRDATA = '0;
    if (hsel_reg && !hwrite_reg) begin
      case (haddr_reg)
        8'h00: HRDATA[NDIGITS-1:0] = blank_reg;
        8'h04: HRDATA[NDIGITS-1:0] = dp_reg;
        8'h08: HRDATA[NDIGITS-1:0] = raw_reg;
        8'h0C: HRDATA[NDIGITS-1:0] = blink_reg;
        8'h20: HRDATA = {20'b0, bright_reg, 7'b0, enable_reg};
        default: ;
      endcase
      for (int d = 0; d < NDIGITS; d++) begin
        if (haddr_reg == code_addr(d)) HRDATA[8*(d%4) +: 8] = code_reg[d];
      end
    end
  end

endmodule

// File: tb/tb_mfp_ahb_sevenseg_gen.sv
// Bench for mfp_ahb_sevenseg_gen: an 8-digit and a 4-digit instance on a shared bus.
// Expected read data and display states are queued, and a monitor compares them.
`timescale 1ns/1ps
module tb_mfp_ahb_sevenseg_gen;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [7:0]  HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        hsel8, hsel4;
  logic [31:0] hrdata8, hrdata4;
  logic [7:0]  dispen8, dispout8, dispout4;
  logic [3:0]  dispen4;

  always #5 HCLK = ~HCLK;

  mfp_ahb_sevenseg_gen #(.NDIGITS(8), .REFRESH_LOG2(4), .BLINK_LOG2(8)) u_dut8 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSEL(hsel8), .HRDATA(hrdata8),
    .DISPENOUT(dispen8), .DISPOUT(dispout8)
  );

  mfp_ahb_sevenseg_gen #(.NDIGITS(4), .REFRESH_LOG2(4), .BLINK_LOG2(8)) u_dut4 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSEL(hsel4), .HRDATA(hrdata4),
    .DISPENOUT(dispen4), .DISPOUT(dispout4)
  );

  typedef struct packed { logic sel4; logic [31:0] exp; } rd_t;
  typedef struct packed { logic sel4; logic [7:0] en; logic [7:0] out; } disp_t;

  rd_t   rd_q[$];
  string rd_name_q[$];
  disp_t disp_q[$];
  string disp_name_q[$];
  int    errors = 0;
  int    checks = 0;
  logic  mon_rd8 = 1'b0;
  logic  mon_rd4 = 1'b0;

  rd_t         m_re;
  disp_t       m_de;
  string       m_nm;
  logic [31:0] m_act;
  logic [7:0]  m_en, m_out;

  function automatic logic [7:0] cur_en(input bit s4);
    return s4 ? {4'h0, dispen4} : dispen8;
  endfunction

  function automatic logic [7:0] anode_of(input bit s4, input int d);
    logic [7:0] v;
    v = 8'hFF;
    v[d] = 1'b0;
    if (s4) v[7:4] = 4'h0;
    return v;
  endfunction

  // Monitor: a read data phase or a queued display expectation is compared at the falling edge.
  always @(posedge HCLK) begin
    mon_rd8 <= hsel8 && !HWRITE && HRESETn;
    mon_rd4 <= hsel4 && !HWRITE && HRESETn;
  end

  always @(negedge HCLK) begin
    if (mon_rd8 || mon_rd4) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: no expectation queued (dut4=%0d)", mon_rd4);
      end else begin
        m_re  = rd_q.pop_front();
        m_nm  = rd_name_q.pop_front();
        m_act = mon_rd4 ? hrdata4 : hrdata8;
        if (m_act !== m_re.exp || m_re.sel4 !== mon_rd4) begin
          errors++;
          $display("FAIL %s: HRDATA got 0x%08h expected 0x%08h", m_nm, m_act, m_re.exp);
        end else begin
          $display("rd   %-14s HRDATA=0x%08h", m_nm, m_act);
        end
      end
    end
    if (disp_q.size() > 0) begin
      m_de  = disp_q.pop_front();
      m_nm  = disp_name_q.pop_front();
      m_en  = cur_en(m_de.sel4);
      m_out = m_de.sel4 ? dispout4 : dispout8;
      checks++;
      if (m_en !== m_de.en || m_out !== m_de.out) begin
        errors++;
        $display("FAIL %s: en/out got 0x%02h/0x%02h expected 0x%02h/0x%02h",
                 m_nm, m_en, m_out, m_de.en, m_de.out);
      end else begin
        $display("disp %-14s en=0x%02h out=0x%02h", m_nm, m_en, m_out);
      end
    end
  end

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", n, act, act, exp, exp);
    end else begin
      $display("chk  %-14s %0d", n, act);
    end
  endtask

  task automatic push_disp(input bit s4, input logic [7:0] en, input logic [7:0] out, input string n);
    disp_q.push_back('{sel4: s4, en: en, out: out});
    disp_name_q.push_back(n);
  endtask

  task automatic wr(input bit s4, input logic [7:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    hsel8 = !s4; hsel4 = s4; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    HWDATA = d; hsel8 = 1'b0; hsel4 = 1'b0; HWRITE = 1'b0;
    $display("wr   dut%0d addr=0x%02h data=0x%08h", s4 ? 4 : 8, a, d);
    // let the write land and reach the display outputs
    @(posedge HCLK);
    @(posedge HCLK); #1;
  endtask

  task automatic rd(input bit s4, input logic [7:0] a, input logic [31:0] e, input string n);
    @(posedge HCLK); #1;
    hsel8 = !s4; hsel4 = s4; HWRITE = 1'b0; HADDR = a;
    rd_q.push_back('{sel4: s4, exp: e});
    rd_name_q.push_back(n);
    @(posedge HCLK); #1;
    hsel8 = 1'b0; hsel4 = 1'b0;
  endtask

  task automatic wr_rd(input logic [7:0] a, input logic [31:0] d, input string n);
    @(posedge HCLK); #1;
    hsel8 = 1'b1; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    HWDATA = d; HWRITE = 1'b0;
    rd_q.push_back('{sel4: 1'b0, exp: d});
    rd_name_q.push_back(n);
    @(posedge HCLK); #1;
    hsel8 = 1'b0;
    @(posedge HCLK); #1;
  endtask

  task automatic wait_anode(input bit s4, input logic [7:0] tgt, input string n);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(posedge HCLK); #1;
      if (cur_en(s4) == tgt) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s: anode 0x%02h never seen, last 0x%02h", n, tgt, cur_en(s4));
    end
  endtask

  task automatic check_digit(input bit s4, input int d, input logic [7:0] out, input string n);
    wait_anode(s4, anode_of(s4, d), n);
    push_disp(s4, anode_of(s4, d), out, n);
  endtask

  // Scan step from one digit to the next, then measure the new slot's length.
  task automatic slot_after(input bit s4, input int from, input int to, input logic [7:0] out, input string n);
    int cnt;
    bit done;
    wait_anode(s4, anode_of(s4, from), n);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge HCLK); #1;
      if (cur_en(s4) != anode_of(s4, from)) done = 1'b1;
    end
    push_disp(s4, anode_of(s4, to), out, {n, "_step"});
    cnt = 1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge HCLK); #1;
      if (cur_en(s4) != anode_of(s4, to)) done = 1'b1;
      else cnt++;
    end
    chk({n, "_len"}, cnt, 16);
  endtask

  task automatic count_lit(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge HCLK); #1;
      if (dispen8 != 8'hFF) cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c1, c2;
    HRESETn = 1'b1;
    HADDR = '0; HWDATA = '0; HWRITE = 1'b0; hsel8 = 1'b0; hsel4 = 1'b0;
    #1 HRESETn = 1'b0;
    #1;
    chk("rst_en", int'(dispen8), 'hFF);
    chk("rst_out", int'(dispout8), 'hFF);
    chk("rst_hrdata", int'(hrdata8), 0);
    @(posedge HCLK); #1;
    push_disp(1'b0, 8'hFF, 8'hFF, "rst_held");
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // first digit right after release; index advances after 16 cycles
    @(posedge HCLK); #1;
    push_disp(1'b0, 8'hFE, 8'hC0, "first_digit");
    repeat (15) @(posedge HCLK);
    #1 push_disp(1'b0, 8'hFE, 8'hC0, "slot0_end");
    @(posedge HCLK); #1;
    push_disp(1'b0, 8'hFD, 8'hC0, "idx_to_1");

    rd(1'b0, 8'h00, 32'h0000_00F0, "rst_blank");
    rd(1'b0, 8'h04, 32'h0000_00F7, "rst_dp");
    rd(1'b0, 8'h20, 32'h0000_0F01, "rst_ctrl");
    rd(1'b0, 8'h08, 32'h0, "rst_raw");
    rd(1'b0, 8'h0C, 32'h0, "rst_blink");
    rd(1'b0, 8'h10, 32'h0, "rst_code0");
    rd(1'b1, 8'h00, 32'h0000_000C, "rst_blank4");
    rd(1'b1, 8'h04, 32'h0000_0007, "rst_dp4");

    // hex decode on digits 0..3
    wr_rd(8'h00, 32'h0, "blank_wr_rd");
    wr(1'b0, 8'h10, 32'h0F0A_0100);
    rd(1'b0, 8'h10, 32'h0F0A_0100, "code0_rb");
    check_digit(1'b0, 0, 8'hC0, "hex_0");
    check_digit(1'b0, 1, 8'hF9, "hex_1");
    check_digit(1'b0, 2, 8'h88, "hex_A");
    check_digit(1'b0, 3, 8'h0E, "hex_F_dp");
    check_digit(1'b0, 4, 8'hC0, "hex_0_d4");
    slot_after(1'b0, 7, 0, 8'hC0, "wrap8");

    // raw mode, special glyphs, ignored code bits
    wr(1'b0, 8'h08, 32'h1);
    wr(1'b0, 8'h10, 32'h0F0A_015A);
    wr(1'b0, 8'h14, 32'h1312_11E9);
    rd(1'b0, 8'h08, 32'h1, "raw_rb");
    rd(1'b0, 8'h14, 32'h1312_11E9, "code1_rb");
    check_digit(1'b0, 0, 8'hDA, "raw_5A");
    check_digit(1'b0, 1, 8'hF9, "hex_1_again");
    check_digit(1'b0, 4, 8'h90, "hex_E9");
    check_digit(1'b0, 5, 8'hBF, "dash");
    check_digit(1'b0, 6, 8'hF7, "underscore");
    check_digit(1'b0, 7, 8'hFF, "blank_glyph");

    // unmapped address
    wr(1'b0, 8'h24, 32'hFFFF_FFFF);
    rd(1'b0, 8'h24, 32'h0, "unmapped_24");
    rd(1'b0, 8'h00, 32'h0, "blank_kept");

    // PWM brightness and global enable
    wr(1'b0, 8'h20, 32'h0000_0001);
    count_lit(32, c);
    chk("pwm_bright0", c, 2);
    wr(1'b0, 8'h20, 32'h0000_0701);
    count_lit(32, c);
    chk("pwm_bright7", c, 16);
    wr(1'b0, 8'h20, 32'h0000_0000);
    count_lit(32, c);
    chk("disabled", c, 0);
    rd(1'b0, 8'h20, 32'h0, "ctrl_rb");
    wr(1'b0, 8'h20, 32'h0000_0F01);

    // blink on digit 1 only
    wr(1'b0, 8'h0C, 32'h2);
    rd(1'b0, 8'h0C, 32'h2, "blink_rb");
    c1 = 0; c2 = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge HCLK); #1;
      if (dispen8 == 8'hFD) c1++;
      if (dispen8 == 8'hFB) c2++;
    end
    chk("blink_d1", c1, 16);
    chk("blink_d2", c2, 32);
    wr(1'b0, 8'h0C, 32'h0);

    // 4-digit instance: masked register bits, map edges, scan wrap
    wr(1'b1, 8'h00, 32'hFFFF_FFF0);
    rd(1'b1, 8'h00, 32'h0, "blank4_mask");
    wr(1'b1, 8'h14, 32'hFFFF_FFFF);
    rd(1'b1, 8'h14, 32'h0, "code4_w1");
    rd(1'b1, 8'h3C, 32'h0, "unmapped_3C");
    rd(1'b1, 8'h10, 32'h0, "code4_w0");
    check_digit(1'b1, 3, 8'h40, "d4_dp");
    slot_after(1'b1, 3, 0, 8'hC0, "wrap4");

    // asynchronous reset in the middle of a lit slot
    wait_anode(1'b0, 8'hFB, "pre_reset");
    @(posedge HCLK); #3;
    HRESETn = 1'b0;
    #1;
    chk("async_en8", int'(dispen8), 'hFF);
    chk("async_out8", int'(dispout8), 'hFF);
    chk("async_en4", int'(dispen4), 'hF);
    chk("async_out4", int'(dispout4), 'hFF);
    @(posedge HCLK); #1;
    push_disp(1'b0, 8'hFF, 8'hFF, "reset_hold");
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    push_disp(1'b0, 8'hFE, 8'hC0, "restart_d0");
    rd(1'b0, 8'h00, 32'h0000_00F0, "post_blank");
    rd(1'b0, 8'h10, 32'h0, "post_code0");
    rd(1'b0, 8'h20, 32'h0000_0F01, "post_ctrl");

    repeat (3) @(posedge HCLK);
    #1;
    checks++;
    if (rd_q.size() != 0 || disp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads and %0d display entries left, expected 0 and 0",
               rd_q.size(), disp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
